shift_sequencer: RTL and testbench

- Control stage directly upstream of the parallel-load shift register (SEL/DATA_IN/Ileft/Iright/OUT interface).
- Accepts one command per transaction over a valid/ready handshake: word, direction, shift count, fill bit.
- Sequences the register: parallel load, then COUNT shift cycles, then hold, then a DONE pulse.
- Lets higher-level logic request "load X and shift by k" without driving SEL cycle by cycle.

---
 rtl/shift_seq_pkg.sv | 22 ++
 rtl/shift_seq_cnt.sv | 42 ++++
 rtl/shift_sequencer.sv | 136 +++++++++++++
 tb/tb_shift_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: register mode encodings,
// controller state type and the shift-count clamp.
package shift_seq_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LOAD  = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // A shift count larger than the register width saturates at the width.
  function automatic int clamp_count(input int count, input int n);
    return (count > n) ? n : count;
  endfunction

endpackage

// File: rtl/shift_seq_cnt.sv
// Loadable down-counter for the shift phase; last flags the final shift cycle.
module shift_seq_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          last
);
  import shift_seq_pkg::*;

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: load wins over decrement, and the counter never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven controller for a parallel-load shift register: load, shift COUNT times, pulse DONE.
// Define SHIFT_SEQ_ROTATE_EN to feed the register's outgoing bit back in (rotate) instead of CMD_FILL.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = $clog2(N+1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [N-1:0]  CMD_DATA,
  input  logic          CMD_DIR,
  input  logic [CW-1:0] CMD_COUNT,
  input  logic          CMD_FILL,
  input  logic [N-1:0]  SR_Q,
  output logic [1:0]    SEL,
  output logic [N-1:0]  DATA_OUT,
  output logic          ILEFT,
  output logic          IRIGHT,
  output logic          BUSY,
  output logic          DONE
);

  state_e        state_d, state_q;
  logic [N-1:0]  data_d, data_q;
  logic          dir_d, dir_q;
  logic          fill_d, fill_q;
  logic [1:0]    sel_d, sel_q;
  logic          fill_out_d, fill_out_q;
  logic          busy_d, busy_q;
  logic          done_d, done_q;
  logic          ready_d, ready_q;
  logic          cnt_load_s, cnt_dec_s, cnt_last_s;
  logic [CW-1:0] cnt_s, count_clamped_s;

  assign count_clamped_s = CW'(clamp_count(int'(CMD_COUNT), N));

  shift_seq_cnt #(.CW(CW)) u_cnt (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (cnt_load_s),
    .load_val (count_clamped_s),
    .dec      (cnt_dec_s),
    .cnt      (cnt_s),
    .last     (cnt_last_s)
  );

  // Next state, command capture, and outputs decoded from the upcoming state so they can be registered.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    dir_d      = dir_q;
    fill_d     = fill_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    sel_d      = SEL_HOLD;
    fill_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (CMD_VALID && ready_q) begin
          state_d    = LOAD;
          data_d     = CMD_DATA;
          dir_d      = CMD_DIR;
          fill_d     = CMD_FILL;
          cnt_load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD:    state_d = (cnt_s != {CW{1'b0}}) ? SHIFT : FINISH;
      SHIFT: begin
        cnt_dec_s = 1'b1;
        state_d   = cnt_last_s ? FINISH : SHIFT;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      LOAD:  sel_d = SEL_LOAD;
      SHIFT: begin
        sel_d      = dir_d ? SEL_RIGHT : SEL_LEFT;
        fill_out_d = fill_d;
      end
      default: sel_d = SEL_HOLD;
    endcase
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
    ready_d = (state_d == IDLE);
  end

  // State, latched command and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      data_q     <= {N{1'b0}};
      dir_q      <= 1'b0;
      fill_q     <= 1'b0;
      sel_q      <= SEL_HOLD;
      fill_out_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      dir_q      <= dir_d;
      fill_q     <= fill_d;
      sel_q      <= sel_d;
      fill_out_q <= fill_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign SEL       = sel_q;
  assign DATA_OUT  = data_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CMD_READY = ready_q;

`ifdef SHIFT_SEQ_ROTATE_EN
  // The bit leaving the register this cycle is fed straight back in, so it must track SR_Q live.
  logic rot_bit_s;
  assign rot_bit_s = dir_q ? SR_Q[0] : SR_Q[N-1];
  assign ILEFT     = (state_q == SHIFT) ? rot_bit_s : 1'b0;
  assign IRIGHT    = (state_q == SHIFT) ? rot_bit_s : 1'b0;
`else
  assign ILEFT  = fill_out_q;
  assign IRIGHT = fill_out_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: shift_sequencer driving a behavioural shift register, checked against a reference model.
module tb_shift_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [7:0] CMD_DATA;
  logic       CMD_DIR;
  logic [3:0] CMD_COUNT;
  logic       CMD_FILL;
  logic [7:0] SR_Q;
  logic [1:0] SEL;
  logic [7:0] DATA_OUT;
  logic       ILEFT, IRIGHT, BUSY, DONE;

  int checks = 0;
  int errors = 0;
  int last_wait = 0;

  shift_sequencer #(.N(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DATA(CMD_DATA), .CMD_DIR(CMD_DIR), .CMD_COUNT(CMD_COUNT), .CMD_FILL(CMD_FILL),
    .SR_Q(SR_Q), .SEL(SEL), .DATA_OUT(DATA_OUT), .ILEFT(ILEFT), .IRIGHT(IRIGHT),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Downstream parallel-load shift register.
  always_ff @(posedge CLK) begin
    case (SEL)
      2'b01:   SR_Q <= DATA_OUT;
      2'b10:   SR_Q <= {SR_Q[6:0], ILEFT};
      2'b11:   SR_Q <= {IRIGHT, SR_Q[7:1]};
      default: SR_Q <= SR_Q;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Final register word after loading d and performing min(c,8) shifts.
  function automatic logic [7:0] model(input logic [7:0] d, input logic dr, input int c, input logic f);
    int s;
    logic [15:0] t;
    logic [15:0] m;
    s = (c > 8) ? 8 : c;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (!dr) begin
      t = {d, d} << s;
      return t[15:8];
    end
    t = {d, d} >> s;
    return t[7:0];
`else
    if (!dr) begin
      t = {8'h00, d} << s;
      m = (16'd1 << s) - 16'd1;
      return t[7:0] | (f ? m[7:0] : 8'h00);
    end
    t = {d, 8'h00} >> s;
    m = 16'hFF00 >> s;
    return t[15:8] | (f ? m[7:0] : 8'h00);
`endif
  endfunction

  task automatic issue(input logic [7:0] d, input logic dr, input logic [3:0] c, input logic f, input bit keep);
    int waited;
    waited = 0;
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_DATA = d; CMD_DIR = dr; CMD_COUNT = c; CMD_FILL = f;
    while (CMD_READY !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    chk("ready_wait", 32'(CMD_READY), 32'd1);
    last_wait = waited;
    @(posedge CLK);
    #1;
    if (!keep) begin
      CMD_VALID = 1'b0;
      CMD_DATA  = 8'($urandom);
      CMD_DIR   = 1'($urandom);
      CMD_COUNT = 4'($urandom);
      CMD_FILL  = 1'($urandom);
    end
  endtask

  // Walks every cycle of a transaction accepted at the last edge and checks the control sequence.
  task automatic check_txn(input logic [7:0] d, input logic dr, input logic [3:0] c, input logic f);
    int cc;
    logic [1:0] exp_sel;
    cc = (int'(c) > 8) ? 8 : int'(c);
    for (int k = 1; k <= cc + 2; k++) begin
      @(negedge CLK);
      if (k == 1) exp_sel = 2'b01;
      else if (k <= cc + 1) exp_sel = dr ? 2'b11 : 2'b10;
      else exp_sel = 2'b00;
      chk("sel", 32'(SEL), 32'(exp_sel));
      chk("busy", 32'(BUSY), 32'd1);
      chk("ready_low", 32'(CMD_READY), 32'd0);
      chk("done", 32'(DONE), 32'(k == cc + 2));
      if (k == 1) chk("data_out", 32'(DATA_OUT), 32'(d));
`ifndef SHIFT_SEQ_ROTATE_EN
      if (k > 1 && k <= cc + 1) begin
        chk("ileft", 32'(ILEFT), 32'(f));
        chk("iright", 32'(IRIGHT), 32'(f));
      end
`endif
      if (k == cc + 2) chk("sr_final", 32'(SR_Q), 32'(model(d, dr, int'(c), f)));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] saved;
    logic [7:0] rd;
    logic       rdir, rf;
    logic [3:0] rc;

    RST_N = 1'b0; CMD_VALID = 1'b0; CMD_DATA = 8'h00; CMD_DIR = 1'b0; CMD_COUNT = 4'd0; CMD_FILL = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_sel", 32'(SEL), 32'd0);
    chk("rst_data", 32'(DATA_OUT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_ileft", 32'(ILEFT), 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      CMD_DATA = 8'($urandom); CMD_COUNT = 4'($urandom);
      chk("idle_sel", 32'(SEL), 32'd0);
      chk("idle_ready", 32'(CMD_READY), 32'd1);
      chk("idle_busy", 32'(BUSY), 32'd0);
      chk("idle_done", 32'(DONE), 32'd0);
    end

    issue(8'hFF, 1'b0, 4'd3, 1'b0, 1'b0);  check_txn(8'hFF, 1'b0, 4'd3, 1'b0);
    issue(8'h81, 1'b1, 4'd2, 1'b1, 1'b0);  check_txn(8'h81, 1'b1, 4'd2, 1'b1);
    issue(8'h5A, 1'b0, 4'd0, 1'b1, 1'b0);  check_txn(8'h5A, 1'b0, 4'd0, 1'b1);
    issue(8'hA5, 1'b1, 4'd15, 1'b0, 1'b0); check_txn(8'hA5, 1'b1, 4'd15, 1'b0);
    issue(8'h81, 1'b0, 4'd1, 1'b0, 1'b0);  check_txn(8'h81, 1'b0, 4'd1, 1'b0);
    issue(8'h81, 1'b0, 4'd8, 1'b1, 1'b0);  check_txn(8'h81, 1'b0, 4'd8, 1'b1);

    // Back-to-back with CMD_VALID held high throughout the first command.
    issue(8'h3C, 1'b0, 4'd2, 1'b1, 1'b1);
    CMD_DATA = 8'hC3; CMD_DIR = 1'b1; CMD_COUNT = 4'd4; CMD_FILL = 1'b0;
    check_txn(8'h3C, 1'b0, 4'd2, 1'b1);
    issue(8'hC3, 1'b1, 4'd4, 1'b0, 1'b0);
    chk("b2b_no_wait", 32'(last_wait), 32'd0);
    check_txn(8'hC3, 1'b1, 4'd4, 1'b0);

    // Reset in the middle of SHIFT aborts without DONE and leaves the register alone.
    issue(8'h96, 1'b0, 4'd6, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_sel", 32'(SEL), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    saved = SR_Q;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("abort_no_done", 32'(DONE), 32'd0);
      chk("abort_hold", 32'(SEL), 32'd0);
    end
    chk("abort_sr_kept", 32'(SR_Q), 32'(saved));

    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      rd = 8'($urandom); rdir = 1'($urandom); rc = 4'($urandom); rf = 1'($urandom);
      issue(rd, rdir, rc, rf, 1'b0);
      check_txn(rd, rdir, rc, rf);
    end

    @(negedge CLK);
    chk("end_ready", 32'(CMD_READY), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
